// File: rtl/regfile_pkg.sv
// Shared types, default sizes and address qualification for the
// multi-port integer register file and its dump stream.
package regfile_pkg;

    // Default register width and register count.
    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;

    // Dump stream controller states.
    typedef enum logic {
        DUMP_IDLE   = 1'b0,
        DUMP_STREAM = 1'b1
    } dump_state_t;

    // An address names a writable register when it is not x0 and lies
    // inside the implemented register range.
    function automatic logic reg_qualify(input int addr, input int nregs);
        return (addr != 0) && (addr < nregs);
    endfunction

endpackage

// File: rtl/regfile_dump_ctrl.sv
// Dump stream controller: walks register indices 0..NREGS-1, one beat per
// valid/ready handshake. Each loaded beat captures the bypassed read value
// of its index, so a beat carries the content the register holds after the
// loading edge, and the captured beat stays frozen while the consumer stalls.
module regfile_dump_ctrl
    import regfile_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            dump_req,
    input  logic            dump_ready,
    output logic [AW-1:0]   rd_addr,
    input  logic [XLEN-1:0] rd_data,
    output logic            dump_busy,
    output logic            dump_valid,
    output logic [AW-1:0]   dump_idx,
    output logic [XLEN-1:0] dump_data,
    output logic            dump_last
);

    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

    dump_state_t     state_q, state_d;
    logic [AW-1:0]   idx_q,   idx_d;
    logic [XLEN-1:0] data_q,  data_d;
    logic            last_q,  last_d;

    // The extra read port always looks one index ahead of the current beat,
    // which is exactly the index loaded on the next handshake.
    assign rd_addr = idx_q + 1'b1;

    // State and beat registers; reset aborts a dump immediately.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge values of the others, independent of statement order.
        if (rst) begin
            state_q <= DUMP_IDLE;
            idx_q   <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    // Next-state logic: start on request, advance on handshake, stop after
    // the handshake of the last beat.
    always_comb begin
        // NOTE: every target gets a default first, so no path through the
        // case statement can leave a signal unassigned and infer a latch.
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        last_d  = last_q;

        case (state_q)
            DUMP_IDLE: begin
                if (dump_req) begin
                    // Beat 0 is x0, which always reads zero.
                    state_d = DUMP_STREAM;
                    idx_d   = '0;
                    data_d  = '0;
                    last_d  = 1'b0;
                end
            end

            DUMP_STREAM: begin
                // dump_req is deliberately not looked at here: a request
                // during a dump, even on the final handshake, is dropped.
                if (dump_ready) begin
                    if (last_q) begin
                        state_d = DUMP_IDLE;
                        idx_d   = '0;
                        data_d  = '0;
                        last_d  = 1'b0;
                    end else begin
                        idx_d  = rd_addr;
                        data_d = rd_data;
                        last_d = (rd_addr == LAST_IDX);
                    end
                end
            end

            default: begin
                state_d = DUMP_IDLE;
            end
        endcase
    end

    assign dump_busy  = (state_q == DUMP_STREAM);
    assign dump_valid = dump_busy;
    assign dump_idx   = idx_q;
    assign dump_data  = data_q;
    assign dump_last  = last_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file for the pipelined core: NRD combinational
// read ports with same-cycle write bypass, NWR write ports where the higher
// numbered port wins on an address conflict, x0 hardwired to zero, and a
// valid/ready dump stream that walks every register for the trace path.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NRD   = 2,
    parameter int NWR   = 1,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rs_addr,
    output logic [NRD*XLEN-1:0] rs_data,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic                dump_req,
    output logic                dump_busy,
    output logic                dump_valid,
    input  logic                dump_ready,
    output logic [AW-1:0]       dump_idx,
    output logic [XLEN-1:0]     dump_data,
    output logic                dump_last
);

    // The dump controller owns one extra read port after the NRD core ports.
    localparam int NPORT = NRD + 1;

    logic [XLEN-1:0]       regs_q [NREGS];
    logic [NWR-1:0]        wr_ok;
    logic [NPORT*AW-1:0]   port_addr;
    logic [NPORT*XLEN-1:0] port_data;
    logic [AW-1:0]         dump_rd_addr;
    logic [XLEN-1:0]       dump_rd_data;

    // A write commits only for a nonzero, in-range address.
    for (genvar w = 0; w < NWR; w++) begin : g_wr_ok
        assign wr_ok[w] = wr_en[w] && reg_qualify(int'(wr_addr[w*AW +: AW]), NREGS);
    end

    // Register storage; later write ports are applied last so they win.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the storage array is reset as well, because architectural
        // registers must read zero after reset, not X.
        if (rst) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            for (int w = 0; w < NWR; w++) begin
                if (wr_ok[w]) begin
                    regs_q[wr_addr[w*AW +: AW]] <= wr_data[w*XLEN +: XLEN];
                end
            end
        end
    end

    assign port_addr    = {dump_rd_addr, rs_addr};
    assign rs_data      = port_data[NRD*XLEN-1:0];
    assign dump_rd_data = port_data[NRD*XLEN +: XLEN];

    // One read mux per port: zero for x0 or out of range, otherwise the
    // winning same-cycle write if any, otherwise the stored value.
    for (genvar p = 0; p < NPORT; p++) begin : g_rd
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;

        assign addr = port_addr[p*AW +: AW];

        // Bypass mux for this port; the loop order gives the last port priority.
        always_comb begin
            data = '0;
            if (reg_qualify(int'(addr), NREGS)) begin
                data = regs_q[addr];
                for (int w = 0; w < NWR; w++) begin
                    if (wr_ok[w] && (wr_addr[w*AW +: AW] == addr)) begin
                        data = wr_data[w*XLEN +: XLEN];
                    end
                end
            end
        end

        assign port_data[p*XLEN +: XLEN] = data;
    end

    regfile_dump_ctrl #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .AW    (AW)
    ) u_dump_ctrl (
        .clk        (clk),
        .rst        (rst),
        .dump_req   (dump_req),
        .dump_ready (dump_ready),
        .rd_addr    (dump_rd_addr),
        .rd_data    (dump_rd_data),
        .dump_busy  (dump_busy),
        .dump_valid (dump_valid),
        .dump_idx   (dump_idx),
        .dump_data  (dump_data),
        .dump_last  (dump_last)
    );

endmodule
